// File: rtl/muldiv_unit.sv
// muldiv_unit: 32-bit iterative multiply/divide unit with HI/LO result registers.
// Multiplication is shift-add on operand magnitudes and division is restoring
// division on magnitudes, one bit per cycle for 32 cycles. A final FIX cycle
// applies signs and the divide-by-zero rule, then writes hi/lo.
module muldiv_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  input  logic        wr_hi,
  input  logic        wr_lo,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } state_t;

  // Two's-complement magnitude of v when it is treated as signed.
  function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
    mag32 = (is_signed && v[31]) ? (~v + 32'd1) : v;
  endfunction

  state_t      state_r;
  state_t      state_s;
  logic [4:0]  cnt_r;
  logic        busy_r;
  logic        done_r;
  logic [31:0] hi_r;
  logic [31:0] lo_r;

  // Operation context captured at the start edge.
  logic [1:0]  op_r;
  logic [31:0] a_r;
  logic        neg_q_r;    // negate product / quotient
  logic        neg_r_r;    // negate remainder
  logic        dz_r;       // divisor was zero
  logic [63:0] acc_r;      // mul: {partial, multiplier}; div: {remainder, quotient}
  logic [31:0] dvs_r;      // mul: multiplicand magnitude; div: divisor magnitude

  logic        accept_s;
  logic [31:0] mag_a_s;
  logic [31:0] mag_b_s;
  logic [32:0] mul_sum_s;
  logic [32:0] div_shift_s;
  logic [33:0] div_diff_s;
  logic        div_ok_s;
  logic [63:0] prod_neg_s;
  logic [31:0] fix_hi_s;
  logic [31:0] fix_lo_s;

  assign busy = busy_r;
  assign done = done_r;
  assign hi   = hi_r;
  assign lo   = lo_r;

  // Start acceptance and signed operand magnitudes.
  always_comb begin
    accept_s = (state_r == IDLE) && start && !flush;
    mag_a_s  = mag32(a, op[0]);
    mag_b_s  = mag32(b, op[0]);
  end

  // Next-state logic; flush always returns an in-flight operation to IDLE.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_s = op[1] ? DIV : MUL;
        end else begin
          state_s = IDLE;
        end
      end
      MUL, DIV: begin
        if (flush) begin
          state_s = IDLE;
        end else if (cnt_r == 5'd31) begin
          state_s = FIX;
        end else begin
          state_s = state_r;
        end
      end
      FIX:     state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // One iteration step: shift-add for multiply, trial subtraction for divide.
  always_comb begin
    mul_sum_s   = {1'b0, acc_r[63:32]} + (acc_r[0] ? {1'b0, dvs_r} : 33'd0);
    div_shift_s = {acc_r[63:32], acc_r[31]};
    div_diff_s  = {1'b0, div_shift_s} - {2'b00, dvs_r};
    div_ok_s    = ~div_diff_s[33];
  end

  // Final sign fix-up and divide-by-zero result.
  always_comb begin
    prod_neg_s = ~acc_r + 64'd1;
    fix_hi_s   = 32'd0;
    fix_lo_s   = 32'd0;
    if (!op_r[1]) begin
      fix_hi_s = neg_q_r ? prod_neg_s[63:32] : acc_r[63:32];
      fix_lo_s = neg_q_r ? prod_neg_s[31:0]  : acc_r[31:0];
    end else if (dz_r) begin
      fix_hi_s = a_r;
      fix_lo_s = 32'hFFFF_FFFF;
    end else begin
      fix_hi_s = neg_r_r ? (~acc_r[63:32] + 32'd1) : acc_r[63:32];
      fix_lo_s = neg_q_r ? (~acc_r[31:0] + 32'd1)  : acc_r[31:0];
    end
  end

  // Control registers: state, iteration counter, busy and done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      cnt_r   <= 5'd0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s != IDLE);
      done_r  <= (state_r == FIX) && !flush;
      if ((state_r == MUL) || (state_r == DIV)) begin
        cnt_r <= cnt_r + 5'd1;
      end else begin
        cnt_r <= 5'd0;
      end
    end
  end

  // Datapath: capture operands on accept, then iterate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_r    <= 2'd0;
      a_r     <= 32'd0;
      neg_q_r <= 1'b0;
      neg_r_r <= 1'b0;
      dz_r    <= 1'b0;
      acc_r   <= 64'd0;
      dvs_r   <= 32'd0;
    end else if (accept_s) begin
      op_r    <= op;
      a_r     <= a;
      neg_q_r <= op[0] & (a[31] ^ b[31]);
      neg_r_r <= op[0] & a[31];
      dz_r    <= (b == 32'd0);
      if (op[1]) begin
        acc_r <= {32'd0, mag_a_s};
        dvs_r <= mag_b_s;
      end else begin
        acc_r <= {32'd0, mag_b_s};
        dvs_r <= mag_a_s;
      end
    end else if (state_r == MUL) begin
      acc_r <= {mul_sum_s, acc_r[31:1]};
    end else if (state_r == DIV) begin
      acc_r <= {(div_ok_s ? div_diff_s[31:0] : div_shift_s[31:0]), acc_r[30:0], div_ok_s};
    end
  end

  // Result registers: completed result at FIX, direct writes only while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_r <= 32'd0;
      lo_r <= 32'd0;
    end else if ((state_r == FIX) && !flush) begin
      hi_r <= fix_hi_s;
      lo_r <= fix_lo_s;
    end else if (!busy_r) begin
      if (wr_hi) begin
        hi_r <= wdata;
      end
      if (wr_lo) begin
        lo_r <= wdata;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed and random checks of muldiv_unit with a result
// scoreboard. Inputs change and outputs are sampled on the falling clock edge.
module tb_muldiv_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        wr_hi;
  logic        wr_lo;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_checks;
  int n_fail;
  logic [63:0] sb_q[$];

  muldiv_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .flush (flush),
    .wr_hi (wr_hi),
    .wr_lo (wr_lo),
    .wdata (wdata),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Independent reference for the four operations.
  function automatic logic [63:0] model(input logic [1:0] mop, input logic [31:0] x, input logic [31:0] y);
    longint sx;
    longint sy;
    int ix;
    int iy;
    int iq;
    int ir;
    logic [63:0] res;
    res = 64'd0;
    case (mop)
      2'b00: res = {32'd0, x} * {32'd0, y};
      2'b01: begin
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        res = sx * sy;
      end
      2'b10: begin
        if (y == 32'd0) res = {x, 32'hFFFF_FFFF};
        else res = {x % y, x / y};
      end
      default: begin
        if (y == 32'd0) res = {x, 32'hFFFF_FFFF};
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) res = {32'd0, 32'h8000_0000};
        else begin
          ix = x;
          iy = y;
          iq = ix / iy;
          ir = ix % iy;
          res = {ir, iq};
        end
      end
    endcase
    return res;
  endfunction

  // Drive start for one cycle from a falling edge; returns at the falling edge after E0.
  task automatic launch(input logic [1:0] lop, input logic [31:0] la, input logic [31:0] lb,
                        input logic [63:0] exp, input bit push);
    start = 1'b1;
    op = lop;
    a = la;
    b = lb;
    if (push) sb_q.push_back(exp);
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", {63'd0, busy}, 64'd1);
    check("done_low_after_start", {63'd0, done}, 64'd0);
  endtask

  // Wait (bounded) for done; k0 = edges already elapsed since E0.
  task automatic wait_result(input string tag, input int k0);
    int k;
    int busy_n;
    logic [63:0] exp;
    k = k0;
    busy_n = 0;
    while (done !== 1'b1 && k < 40) begin
      if (busy === 1'b1) busy_n++;
      @(negedge clk);
      k++;
    end
    check({tag, "_latency"}, 64'(k), 64'd33);
    check({tag, "_busy_cycles"}, 64'(busy_n), 64'(33 - k0));
    check({tag, "_busy_low_at_done"}, {63'd0, busy}, 64'd0);
    if (sb_q.size() == 0) begin
      check({tag, "_scoreboard_empty"}, 64'd0, 64'd1);
    end else begin
      exp = sb_q.pop_front();
      check(tag, {hi, lo}, exp);
    end
  endtask

  // Confirm no done pulse appears over n cycles.
  task automatic expect_no_done(input string tag, input int n);
    int seen;
    seen = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen++;
    end
    check(tag, 64'(seen), 64'd0);
  endtask

  initial begin
    logic [63:0] held;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [1:0]  rop;
    n_checks = 0;
    n_fail = 0;
    rst_n = 1'b0;
    start = 1'b0;
    op = 2'b00;
    a = 32'd0;
    b = 32'd0;
    flush = 1'b0;
    wr_hi = 1'b0;
    wr_lo = 1'b0;
    wdata = 32'd0;
    #1;
    check("reset_state", {busy, done, hi, lo}, {1'b0, 1'b0, 64'd0});
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vectors with fixed expected values.
    launch(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b1);
    wait_result("multu_max", 0);
    @(negedge clk);
    check("done_one_cycle", {63'd0, done}, 64'd0);
    launch(2'b01, 32'hFFFF_FFFD, 32'h0000_0005, 64'hFFFF_FFFF_FFFF_FFF1, 1'b1);
    wait_result("mult_neg", 0);
    @(negedge clk);
    launch(2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 64'hFFFF_FFFF_FFFF_FFFD, 1'b1);
    wait_result("div_neg", 0);
    @(negedge clk);
    launch(2'b10, 32'h0000_0064, 32'h0000_0000, 64'h0000_0064_FFFF_FFFF, 1'b1);
    wait_result("divu_by_zero", 0);
    @(negedge clk);
    launch(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 1'b1);
    wait_result("div_overflow", 0);
    @(negedge clk);
    launch(2'b11, 32'hFFFF_FFF0, 32'h0000_0000, 64'hFFFF_FFF0_FFFF_FFFF, 1'b1);
    wait_result("div_by_zero_signed", 0);

    // Back-to-back: start in the done cycle.
    launch(2'b01, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b1);
    wait_result("b2b_first", 0);
    launch(2'b11, 32'h0000_0007, 32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD, 1'b1);
    wait_result("b2b_second", 0);
    @(negedge clk);

    // Start during an operation is ignored.
    launch(2'b10, 32'd1000, 32'd7, model(2'b10, 32'd1000, 32'd7), 1'b1);
    repeat (5) @(negedge clk);
    start = 1'b1;
    op = 2'b00;
    a = 32'h1234_5678;
    b = 32'h0000_0003;
    @(negedge clk);
    start = 1'b0;
    wait_result("ignored_start", 6);
    expect_no_done("no_queued_op", 40);

    // Flush mid-operation keeps hi/lo and produces no done.
    held = {hi, lo};
    launch(2'b00, 32'h0000_1111, 32'h0000_2222, 64'd0, 1'b0);
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy_low", {63'd0, busy}, 64'd0);
    expect_no_done("flush_no_done", 40);
    check("flush_hold", {hi, lo}, held);

    // Flush with start in IDLE drops the start.
    start = 1'b1;
    flush = 1'b1;
    op = 2'b00;
    a = 32'd3;
    b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    flush = 1'b0;
    check("flush_wins_busy", {63'd0, busy}, 64'd0);
    expect_no_done("flush_wins_no_done", 40);

    // Direct writes while idle, to both registers.
    wr_hi = 1'b1;
    wr_lo = 1'b1;
    wdata = 32'hCAFE_F00D;
    @(negedge clk);
    wr_hi = 1'b0;
    wr_lo = 1'b0;
    check("write_both", {hi, lo}, {32'hCAFE_F00D, 32'hCAFE_F00D});

    // Write while busy is ignored.
    launch(2'b00, 32'd9, 32'd9, 64'd81, 1'b1);
    repeat (3) @(negedge clk);
    wr_lo = 1'b1;
    wdata = 32'h0BAD_0BAD;
    @(negedge clk);
    wr_lo = 1'b0;
    @(negedge clk);
    check("write_busy_ignored", {32'd0, lo}, {32'd0, 32'hCAFE_F00D});
    wait_result("after_busy_write", 5);
    @(negedge clk);

    // Write in the start cycle takes effect, then the result overwrites it.
    wr_hi = 1'b1;
    wdata = 32'h5555_AAAA;
    launch(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd1, 1'b1);
    wr_hi = 1'b0;
    check("write_with_start", {32'd0, hi}, {32'd0, 32'h5555_AAAA});
    wait_result("write_then_result", 0);
    @(negedge clk);

    // Reset mid-operation clears everything immediately.
    launch(2'b00, 32'h0000_FFFF, 32'h0000_FFFF, 64'd0, 1'b0);
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async_reset", {busy, done, hi, lo}, {1'b0, 1'b0, 64'd0});
    @(negedge clk);
    rst_n = 1'b1;
    launch(2'b10, 32'd100, 32'd9, 64'h0000_0001_0000_000B, 1'b1);
    wait_result("after_reset", 0);
    @(negedge clk);

    // Random operands against the reference model.
    for (int i = 0; i < 6; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = (i == 5) ? 32'd0 : $urandom;
      if (i == 2) rb = 32'($urandom_range(1, 15));
      launch(rop, ra, rb, model(rop, ra, rb), 1'b1);
      wait_result("random", 0);
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, named clk and rst_n.
REQ-002 The block SHALL have no parameters; the datapath width SHALL be fixed at 32 bits.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 start  input  1  request a new operation; sampled only in IDLE.
REQ-006 op  input  2  operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
REQ-007 a  input  32  multiplicand or dividend; sampled with start.
REQ-008 b  input  32  multiplier or divisor; sampled with start.
REQ-009 flush  input  1  synchronous cancel of an in-flight operation.
REQ-010 wr_hi  input  1  direct write of wdata to hi (MTHI).
REQ-011 wr_lo  input  1  direct write of wdata to lo (MTLO).
REQ-012 wdata  input  32  data for wr_hi and wr_lo.
REQ-013 busy  output  1  high while an operation is in flight.
REQ-014 done  output  1  one-cycle pulse when hi and lo hold a new result.
REQ-015 hi  output  32  product[63:32] or remainder; registered.
REQ-016 lo  output  32  product[31:0] or quotient; registered.

Function
REQ-017 The FSM SHALL have the states IDLE, MUL, DIV and FIX.
REQ-018 FSM transitions SHALL be as follows:
- IDLE to MUL or DIV on start, by op[1].
- MUL or DIV to FIX after exactly 32 iteration cycles.
- FIX to IDLE unconditionally.
REQ-019 The start edge E0 SHALL capture a, b, op and the operand magnitudes; busy SHALL be 1 after E0 through edge E33.
REQ-020 At E33, hi and lo SHALL update, done SHALL become 1 for exactly one cycle, and busy SHALL become 0.
REQ-021 MUL SHALL perform a shift-add on the magnitudes, one multiplier bit per cycle.
REQ-022 For MULT, FIX SHALL negate the 64-bit product when a[31] XOR b[31].
REQ-023 The final result SHALL be {hi,lo} = the exact 64-bit product, signed for MULT and unsigned for MULTU.
REQ-024 DIV SHALL perform restoring division on the magnitudes, one quotient bit per cycle.
REQ-025 For DIV, FIX SHALL apply the signs:
- Quotient negated when a[31] XOR b[31], i.e. truncation toward zero.
- Remainder takes the sign of the dividend.
REQ-026 The final result SHALL be lo = quotient and hi = remainder.
REQ-027 On divide by zero (b = 0), DIVU and DIV SHALL give lo = 0xFFFFFFFF and hi = a, with normal latency and no error flag.
REQ-028 On signed overflow (DIV 0x80000000 / 0xFFFFFFFF), the result SHALL be lo = 0x80000000 and hi = 0x00000000.
REQ-029 start while busy = 1 SHALL be ignored; there SHALL be no queueing.
REQ-030 flush while busy = 1 SHALL return the FSM to IDLE at the next edge, with busy = 0, hi and lo unchanged, and no done pulse.
REQ-031 flush and start together in IDLE: flush SHALL win and the start SHALL be dropped.
REQ-032 wr_hi and wr_lo SHALL take effect only when busy = 0 and SHALL be ignored while busy = 1.
REQ-033 A write in the same IDLE cycle as start SHALL take effect; the operation SHALL proceed, and its result SHALL later overwrite the written value.
REQ-034 wr_hi and wr_lo together SHALL write wdata to both registers.
REQ-035 hi and lo SHALL change only at E33 of a completed operation, on a write, or on reset.

Reset
REQ-036 rst_n = 0 SHALL immediately force state = IDLE, busy = 0, done = 0, hi = 0 and lo = 0, regardless of clk.
REQ-037 Reset asserted mid-operation SHALL abort the operation; no done pulse SHALL follow the deassertion of reset.
REQ-038 After rst_n rises, the first start SHALL be accepted at the next rising edge.

Verification
REQ-039 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi = 0xFFFFFFFE, lo = 0x00000001; done at E33; busy high for exactly 33 cycles.
REQ-040 MULT 0xFFFFFFFD x 0x00000005 -> hi = 0xFFFFFFFF, lo = 0xFFFFFFF1.
REQ-041 DIV 0xFFFFFFF9 / 0x00000002 -> lo = 0xFFFFFFFD, hi = 0xFFFFFFFF.
REQ-042 DIVU 0x00000064 / 0 -> lo = 0xFFFFFFFF, hi = 0x00000064. DIV 0x80000000 / 0xFFFFFFFF -> lo = 0x80000000, hi = 0.
REQ-043 Back-to-back and ignored start:
- start in the done cycle is accepted, with a second done 33 edges later.
- start at E5 of an operation is ignored, and its operands never appear in the result.
REQ-044 Abort and write cases:
- flush at E10 -> busy = 0 at E11, hi and lo keep their prior values, no done.
- rst_n low at E20 -> all outputs 0 immediately.
- wr_lo while busy -> lo unchanged.
